// File: rtl/swap_sort_pkg.sv
// ---------------------------------------------------------------------------
// swap_sort_pkg
// Shared types and helpers for the swap_sort_sequencer slice.
//   sortState_t     : sequencer FSM states
//   swapCountWidth  : width of the swap counter for a given element count
//   firstPairIndex  : index of the first compared pair in a given pass
// ---------------------------------------------------------------------------
package swap_sort_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RELEASE,
        ADVANCE,
        DONE
    } sortState_t;

    // Enough bits to hold Depth*Depth, which bounds the swaps of one sort.
    function automatic int swapCountWidth(input int depth);
        return $clog2(depth * depth) + 1;
    endfunction

    // Even passes start at pair (0,1), odd passes at pair (1,2).
    function automatic int firstPairIndex(input int pass);
        return pass % 2;
    endfunction

endpackage

// File: rtl/swap_sort_sequencer_fin_synchronizer.sv
// ---------------------------------------------------------------------------
// fin_synchronizer
// Multi-flop synchronizer that brings the compareSwap fin signal, which is
// generated by self-timed logic, into the clk domain.
//   clk     : system clock
//   rst     : asynchronous active-high reset, clears every stage to 0
//   i_async : asynchronous input
//   o_sync  : synchronized output, Stages cycles of latency
// ---------------------------------------------------------------------------
module fin_synchronizer #(
    parameter int Stages = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [Stages-1:0] r_chain;

    // Shift the asynchronous level through the chain; only the last stage
    // is trusted to be metastability-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[Stages-2:0], i_async};
        end
    end

    assign o_sync = r_chain[Stages-1];

endmodule

// File: rtl/swap_sort_sequencer.sv
// ---------------------------------------------------------------------------
// swap_sort_sequencer
// Sorts Depth elements ascending with an odd-even transposition sort,
// time-sharing one external self-timed compareSwap datapath through a
// four-phase req/fin handshake.
//   clk, rst            : clock, asynchronous active-high reset
//   i_req / o_fin       : upstream four-phase start / complete handshake
//   i_dataIn            : unsorted elements, element k at [k*Width +: Width]
//   o_dataOut           : element array, same packing, valid while o_fin=1
//   o_busy              : high from accepted request until o_fin rises
//   o_swapCount         : compares that changed element order, saturating
//   o_cmpReq            : request to compareSwap
//   o_cmpA / o_cmpB     : operands, element[i] and element[i+1]
//   i_cmpFin            : compareSwap fin, asynchronous to clk
//   i_cmpSmaller/Bigger : compareSwap results, bundled with i_cmpFin
// ---------------------------------------------------------------------------
module swap_sort_sequencer
    import swap_sort_pkg::*;
#(
    parameter int Width      = 32,
    parameter int Depth      = 8,
    parameter int SyncStages = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_req,
    output logic                              o_fin,
    input  logic [Depth*Width-1:0]            i_dataIn,
    output logic [Depth*Width-1:0]            o_dataOut,
    output logic                              o_busy,
    output logic [swapCountWidth(Depth)-1:0]  o_swapCount,
    output logic                              o_cmpReq,
    output logic [Width-1:0]                  o_cmpA,
    output logic [Width-1:0]                  o_cmpB,
    input  logic                              i_cmpFin,
    input  logic [Width-1:0]                  i_cmpSmaller,
    input  logic [Width-1:0]                  i_cmpBigger
);

    localparam int CountW   = swapCountWidth(Depth);
    localparam int IdxW     = $clog2(Depth);
    localparam int FirstIdx = firstPairIndex(0);

    typedef logic [IdxW-1:0]   idx_t;
    typedef logic [CountW-1:0] count_t;

    localparam count_t CountMax = '1;

    sortState_t       r_state;
    sortState_t       w_nextState;

    logic [Width-1:0] r_elem [Depth];
    idx_t             r_idx;
    idx_t             r_pass;
    count_t           r_swapCount;
    logic [Width-1:0] r_resSmaller;
    logic [Width-1:0] r_resBigger;
    logic [Width-1:0] r_cmpA;
    logic [Width-1:0] r_cmpB;
    logic             r_cmpReq;
    logic             r_busy;
    logic             r_fin;

    logic             w_finS;
    logic             w_start;
    logic             w_sortDone;
    idx_t             w_idxNext;
    idx_t             w_passNext;
    idx_t             w_idxB;
    logic             w_cmpReqNext;
    logic             w_busyNext;
    logic             w_finNext;

    fin_synchronizer #(
        .Stages (SyncStages)
    ) u_finSync (
        .clk     (clk),
        .rst     (rst),
        .i_async (i_cmpFin),
        .o_sync  (w_finS)
    );

    assign w_idxB = r_idx + idx_t'(1);

    // Work out the pair that follows the current one. Stepping off the end
    // of a pass moves to the next pass; a pass with no pair at all (only
    // the odd pass when Depth=2) is skipped in the same step.
    always_comb begin
        int nextIdx;
        int nextPass;
        w_sortDone = 1'b0;
        w_idxNext  = r_idx;
        w_passNext = r_pass;
        nextIdx    = int'(r_idx) + 2;
        nextPass   = int'(r_pass);
        if (nextIdx + 1 >= Depth) begin
            nextPass = nextPass + 1;
            nextIdx  = firstPairIndex(nextPass);
            if (nextIdx + 1 >= Depth) begin
                nextPass = nextPass + 1;
                nextIdx  = firstPairIndex(nextPass);
            end
        end
        if (nextPass >= Depth) begin
            w_sortDone = 1'b1;
        end else begin
            w_idxNext  = idx_t'(nextIdx);
            w_passNext = idx_t'(nextPass);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next-state logic. IDLE refuses new work while the datapath still
    // shows fin, which can happen after a reset in the middle of a compare.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (i_req && !w_finS) w_nextState = ISSUE;
            ISSUE:   if (w_finS)           w_nextState = CAPTURE;
            CAPTURE:                       w_nextState = RELEASE;
            RELEASE: if (!w_finS)          w_nextState = ADVANCE;
            ADVANCE:                       w_nextState = w_sortDone ? DONE : ISSUE;
            DONE:    if (!i_req)           w_nextState = IDLE;
            default:                       w_nextState = IDLE;
        endcase
    end

    // FSM outputs, computed as next values of registers so nothing that
    // reaches the self-timed datapath or the upstream fabric can glitch.
    // cmpReq rises one cycle after ISSUE is entered, so the operands loaded
    // on entry are already settled when the request appears.
    always_comb begin
        w_start      = (r_state == IDLE) && (w_nextState == ISSUE);
        w_cmpReqNext = 1'b0;
        case (r_state)
            ISSUE:   w_cmpReqNext = 1'b1;
            CAPTURE: w_cmpReqNext = r_cmpReq;
            default: w_cmpReqNext = 1'b0;
        endcase
        w_busyNext = (w_nextState == ISSUE)   || (w_nextState == CAPTURE) ||
                     (w_nextState == RELEASE) || (w_nextState == ADVANCE);
        w_finNext  = (w_nextState == DONE);
    end

    // Handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmpReq <= 1'b0;
            r_busy   <= 1'b0;
            r_fin    <= 1'b0;
        end else begin
            r_cmpReq <= w_cmpReqNext;
            r_busy   <= w_busyNext;
            r_fin    <= w_finNext;
        end
    end

    // Operand registers change only when no compare is outstanding: at
    // start-up from the incoming data, and in ADVANCE from the updated array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmpA <= '0;
            r_cmpB <= '0;
        end else if (w_start) begin
            r_cmpA <= i_dataIn[FirstIdx*Width +: Width];
            r_cmpB <= i_dataIn[(FirstIdx+1)*Width +: Width];
        end else if ((r_state == ADVANCE) && !w_sortDone) begin
            r_cmpA <= r_elem[w_idxNext];
            r_cmpB <= r_elem[w_idxNext + idx_t'(1)];
        end
    end

    // Pair index and pass number.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx  <= '0;
            r_pass <= '0;
        end else if (w_start) begin
            r_idx  <= idx_t'(FirstIdx);
            r_pass <= '0;
        end else if ((r_state == ADVANCE) && !w_sortDone) begin
            r_idx  <= w_idxNext;
            r_pass <= w_passNext;
        end
    end

    // Results are taken exactly once, in the first cycle the synchronized
    // fin is seen; the bundled-data rule guarantees they are stable then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resSmaller <= '0;
            r_resBigger  <= '0;
        end else if ((r_state == ISSUE) && w_finS) begin
            r_resSmaller <= i_cmpSmaller;
            r_resBigger  <= i_cmpBigger;
        end
    end

    // Element array and swap counter. A compare counts as a swap when the
    // smaller result differs from the old left element; equal operands
    // therefore never count. The counter saturates instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < Depth; k++) begin
                r_elem[k] <= '0;
            end
            r_swapCount <= '0;
        end else if (w_start) begin
            for (int k = 0; k < Depth; k++) begin
                r_elem[k] <= i_dataIn[k*Width +: Width];
            end
            r_swapCount <= '0;
        end else if (r_state == CAPTURE) begin
            r_elem[r_idx]  <= r_resSmaller;
            r_elem[w_idxB] <= r_resBigger;
            if ((r_resSmaller != r_elem[r_idx]) && (r_swapCount != CountMax)) begin
                r_swapCount <= r_swapCount + count_t'(1);
            end
        end
    end

    // Expose the element array in the same packing as the input bus.
    always_comb begin
        o_dataOut = '0;
        for (int k = 0; k < Depth; k++) begin
            o_dataOut[k*Width +: Width] = r_elem[k];
        end
    end

    assign o_fin       = r_fin;
    assign o_busy      = r_busy;
    assign o_swapCount = r_swapCount;
    assign o_cmpReq    = r_cmpReq;
    assign o_cmpA      = r_cmpA;
    assign o_cmpB      = r_cmpB;

endmodule

// File: tb/tb_swap_sort_sequencer.sv
// ---------------------------------------------------------------------------
// tb_swap_sort_sequencer
// Bench for swap_sort_sequencer: a Depth=4 and a Depth=2 instance, each
// paired with a behavioural self-timed compareSwap with random delay.
// Expected results are pushed to a scoreboard queue when a sort is started
// and popped when the sequencer raises fin.
// ---------------------------------------------------------------------------
module tb_swap_sort_sequencer;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  swaps;
        logic [7:0]  compares;
    } expect_t;

    logic        clk = 1'b0;
    logic        rst;

    logic        req4, fin4, busy4, cmpReq4, cmpFin4;
    logic [31:0] dataIn4, dataOut4;
    logic [4:0]  swapCount4;
    logic [7:0]  cmpA4, cmpB4, cmpSmaller4, cmpBigger4;

    logic        req2, fin2, busy2, cmpReq2, cmpFin2;
    logic [15:0] dataIn2, dataOut2;
    logic [2:0]  swapCount2;
    logic [7:0]  cmpA2, cmpB2, cmpSmaller2, cmpBigger2;

    bit          holdFin4 = 1'b0;
    int          reqEdges4 = 0;
    int          reqEdges2 = 0;
    int          stableViol4 = 0;
    int          stableViol2 = 0;
    logic [7:0]  prevA4 = '0, prevB4 = '0, prevA2 = '0, prevB2 = '0;

    int          checks = 0;
    int          failures = 0;
    expect_t     sbQueue [$];

    swap_sort_sequencer #(.Width(8), .Depth(4), .SyncStages(2)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .i_req        (req4),
        .o_fin        (fin4),
        .i_dataIn     (dataIn4),
        .o_dataOut    (dataOut4),
        .o_busy       (busy4),
        .o_swapCount  (swapCount4),
        .o_cmpReq     (cmpReq4),
        .o_cmpA       (cmpA4),
        .o_cmpB       (cmpB4),
        .i_cmpFin     (cmpFin4),
        .i_cmpSmaller (cmpSmaller4),
        .i_cmpBigger  (cmpBigger4)
    );

    swap_sort_sequencer #(.Width(8), .Depth(2), .SyncStages(2)) dut2 (
        .clk          (clk),
        .rst          (rst),
        .i_req        (req2),
        .o_fin        (fin2),
        .i_dataIn     (dataIn2),
        .o_dataOut    (dataOut2),
        .o_busy       (busy2),
        .o_swapCount  (swapCount2),
        .o_cmpReq     (cmpReq2),
        .o_cmpA       (cmpA2),
        .o_cmpB       (cmpB2),
        .i_cmpFin     (cmpFin2),
        .i_cmpSmaller (cmpSmaller2),
        .i_cmpBigger  (cmpBigger2)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Self-timed compareSwap for the Depth=4 instance. holdFin4 lets the
    // bench keep fin high to emulate a datapath stuck across a reset.
    initial begin
        cmpFin4 = 1'b0; cmpSmaller4 = '0; cmpBigger4 = '0;
        forever begin
            @(posedge cmpReq4);
            repeat ($urandom_range(1, 7)) @(posedge clk);
            #3;
            cmpSmaller4 = (cmpA4 < cmpB4) ? cmpA4 : cmpB4;
            cmpBigger4  = (cmpA4 < cmpB4) ? cmpB4 : cmpA4;
            #1 cmpFin4 = 1'b1;
            wait (cmpReq4 == 1'b0);
            wait (holdFin4 == 1'b0);
            repeat ($urandom_range(1, 7)) @(posedge clk);
            #3 cmpFin4 = 1'b0;
        end
    end

    // Self-timed compareSwap for the Depth=2 instance.
    initial begin
        cmpFin2 = 1'b0; cmpSmaller2 = '0; cmpBigger2 = '0;
        forever begin
            @(posedge cmpReq2);
            repeat ($urandom_range(1, 7)) @(posedge clk);
            #3;
            cmpSmaller2 = (cmpA2 < cmpB2) ? cmpA2 : cmpB2;
            cmpBigger2  = (cmpA2 < cmpB2) ? cmpB2 : cmpA2;
            #1 cmpFin2 = 1'b1;
            wait (cmpReq2 == 1'b0);
            repeat ($urandom_range(1, 7)) @(posedge clk);
            #3 cmpFin2 = 1'b0;
        end
    end

    // Count compares issued to each datapath.
    always @(posedge cmpReq4) reqEdges4++;
    always @(posedge cmpReq2) reqEdges2++;

    // Operands must already be stable the cycle before cmpReq rises and
    // stay stable while it is high.
    always @(negedge clk) begin
        if (cmpReq4 && ((cmpA4 != prevA4) || (cmpB4 != prevB4))) stableViol4++;
        if (cmpReq2 && ((cmpA2 != prevA2) || (cmpB2 != prevB2))) stableViol2++;
        prevA4 = cmpA4; prevB4 = cmpB4;
        prevA2 = cmpA2; prevB2 = cmpB2;
    end

    // Hard stop in case a wait somewhere is never satisfied.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference result: insertion sort for the data, inversion count for
    // the swaps (every adjacent swap removes exactly one inversion), and
    // the closed-form compare count of the transposition sort.
    function automatic expect_t makeExpect(input logic [31:0] vec, input int depth);
        expect_t    e;
        logic [7:0] v [4];
        logic [7:0] t;
        int         inv;
        int         j;
        for (int k = 0; k < 4; k++) v[k] = (k < depth) ? vec[k*8 +: 8] : 8'd0;
        inv = 0;
        for (int a = 0; a < depth; a++)
            for (int b = a + 1; b < depth; b++)
                if (v[a] > v[b]) inv++;
        for (int k = 1; k < depth; k++) begin
            t = v[k];
            j = k - 1;
            while (j >= 0 && v[j] > t) begin
                v[j+1] = v[j];
                j--;
            end
            v[j+1] = t;
        end
        e.data = '0;
        for (int k = 0; k < depth; k++) e.data[k*8 +: 8] = v[k];
        e.swaps    = 8'(inv);
        e.compares = 8'(((depth + 1) / 2) * (depth / 2) + (depth / 2) * ((depth - 1) / 2));
        return e;
    endfunction

    task automatic waitFin4(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (fin4) begin ok = 1'b1; break; end
        end
    endtask

    task automatic waitFin2(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (fin2) begin ok = 1'b1; break; end
        end
    endtask

    // One sort on the Depth=4 instance. With dropEarly, req is withdrawn
    // mid-sort; the sort must still finish and fin pulses for one cycle.
    task automatic applyStimulus4(input logic [31:0] vec, input bit dropEarly);
        expect_t got;
        int      startEdges;
        bit      ok;
        sbQueue.push_back(makeExpect(vec, 4));
        startEdges = reqEdges4;
        @(negedge clk);
        dataIn4 = vec;
        req4    = 1'b1;
        @(negedge clk);
        checkOutput("busyAfterReq4", busy4, 1);
        if (dropEarly) begin
            repeat (5) @(negedge clk);
            req4 = 1'b0;
        end
        waitFin4(ok);
        checkOutput("finRises4", ok, 1);
        got = sbQueue.pop_front();
        checkOutput("dataOut4", dataOut4, got.data);
        checkOutput("swapCount4", swapCount4, 32'(got.swaps));
        checkOutput("compares4", reqEdges4 - startEdges, 32'(got.compares));
        checkOutput("busyAtFin4", busy4, 0);
        if (!dropEarly) begin
            repeat (6) @(negedge clk);
            checkOutput("finHeld4", fin4, 1);
            checkOutput("noRestart4", reqEdges4 - startEdges, 32'(got.compares));
            req4 = 1'b0;
        end
        @(negedge clk);
        checkOutput("finFalls4", fin4, 0);
    endtask

    // One sort on the Depth=2 instance.
    task automatic applyStimulus2(input logic [15:0] vec);
        expect_t got;
        int      startEdges;
        bit      ok;
        sbQueue.push_back(makeExpect({16'd0, vec}, 2));
        startEdges = reqEdges2;
        @(negedge clk);
        dataIn2 = vec;
        req2    = 1'b1;
        waitFin2(ok);
        checkOutput("finRises2", ok, 1);
        got = sbQueue.pop_front();
        checkOutput("dataOut2", {16'd0, dataOut2}, got.data);
        checkOutput("swapCount2", swapCount2, 32'(got.swaps));
        checkOutput("compares2", reqEdges2 - startEdges, 32'(got.compares));
        repeat (4) @(negedge clk);
        checkOutput("finHeld2", fin2, 1);
        req2 = 1'b0;
        @(negedge clk);
        checkOutput("finFalls2", fin2, 0);
    endtask

    // Reset while the datapath holds fin high in the middle of a compare,
    // then request a new sort: it must wait for the datapath to release.
    task automatic applyResetMidSort(input logic [31:0] vec);
        expect_t got;
        int      startEdges;
        bit      ok;
        bit      seen;
        holdFin4 = 1'b1;
        @(negedge clk);
        dataIn4 = vec;
        req4    = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (cmpFin4) begin seen = 1'b1; break; end
        end
        checkOutput("modelFinBeforeReset", seen, 1);
        checkOutput("cmpReqBeforeReset", cmpReq4, 1);
        #1;
        rst  = 1'b1;
        req4 = 1'b0;
        #1;
        checkOutput("cmpReqDropsOnReset", cmpReq4, 0);
        checkOutput("busyDropsOnReset", busy4, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        sbQueue.push_back(makeExpect(vec, 4));
        startEdges = reqEdges4;
        req4 = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("noLoadWhileFinHigh", busy4, 0);
        checkOutput("noCmpReqWhileFinHigh", cmpReq4, 0);
        holdFin4 = 1'b0;
        waitFin4(ok);
        checkOutput("finAfterReset", ok, 1);
        got = sbQueue.pop_front();
        checkOutput("dataOutAfterReset", dataOut4, got.data);
        checkOutput("swapCountAfterReset", swapCount4, 32'(got.swaps));
        checkOutput("comparesAfterReset", reqEdges4 - startEdges, 32'(got.compares));
        req4 = 1'b0;
        @(negedge clk);
        checkOutput("finFallsAfterReset", fin4, 0);
    endtask

    initial begin
        rst = 1'b1;
        req4 = 1'b0; dataIn4 = '0;
        req2 = 1'b0; dataIn2 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("resetFin4", fin4, 0);
        checkOutput("resetBusy4", busy4, 0);
        checkOutput("resetCmpReq4", cmpReq4, 0);
        checkOutput("resetSwapCount4", swapCount4, 0);
        checkOutput("resetDataOut4", dataOut4, 0);
        checkOutput("resetCmpA4", {cmpA4, cmpB4}, 0);
        checkOutput("resetFin2", fin2, 0);
        checkOutput("resetDataOut2", dataOut2, 0);

        // Element 0 sits in the low byte.
        applyStimulus4({8'd1, 8'd2, 8'd3, 8'd4}, 1'b0);     // [4,3,2,1]
        applyStimulus4({8'd4, 8'd3, 8'd2, 8'd1}, 1'b0);     // [1,2,3,4]
        applyStimulus4({8'd7, 8'd7, 8'd7, 8'd7}, 1'b0);     // all equal
        applyStimulus4({8'd1, 8'd128, 8'd0, 8'd255}, 1'b1); // [255,0,128,1]
        for (int r = 0; r < 3; r++) begin
            applyStimulus4($urandom(), 1'b0);
        end
        applyStimulus2({8'd5, 8'd9});                       // [9,5]
        applyStimulus2({8'd3, 8'd3});
        applyResetMidSort({8'd3, 8'd1, 8'd4, 8'd2});        // [2,4,1,3]

        checkOutput("cmpStable4", stableViol4, 0);
        checkOutput("cmpStable2", stableViol2, 0);
        checkOutput("scoreboardEmpty", sbQueue.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/swap_sort_sequencer.md
Name: swap_sort_sequencer

Overview:
Clocked controller that sorts Depth words ascending by time-sharing one external self-timed compareSwap datapath. It runs an odd-even transposition sort and drives the datapath's four-phase req/fin handshake. It exposes its own four-phase req/fin handshake upstream, so it drops into the same flow-control fabric as the other req/fin blocks.

Parameters:
Width, 32, bit width of each element and of the compareSwap a/b/smaller/bigger buses
Depth, 8, number of elements sorted, must be >= 2
SyncStages, 2, flip-flop stages on the asynchronous cmpFin input, must be >= 2

Ports:
clk  input  1  system clock
rst  input  1  reset
req  input  1  start request, four-phase, synchronous to clk
fin  output  1  sort complete, four-phase acknowledge of req
dataIn  input  Depth*Width  unsorted elements; element i = bits [i*Width +: Width]; sampled on accepted req
dataOut  output  Depth*Width  element register array, same packing; valid while fin=1
busy  output  1  high from req acceptance until fin rises
swapCount  output  $clog2(Depth*Depth)+1  compares that changed element order in the last sort
cmpReq  output  1  request to compareSwap
cmpA  output  Width  element[i] of the current pair
cmpB  output  Width  element[i+1] of the current pair
cmpFin  input  1  fin from compareSwap, asynchronous to clk
cmpSmaller  input  Width  compareSwap smaller result, bundled with cmpFin
cmpBigger  input  Width  compareSwap bigger result, bundled with cmpFin

Behaviour:
- One clock: clk. Reset is rst, asynchronous and active-high.
- Reset values: fin=0, busy=0, cmpReq=0, swapCount=0, element array=0, cmpA/cmpB=0, state=IDLE, synchronizer flops=0.
- cmpFin passes through SyncStages flops. The name finS below refers to the synchronized value.
- cmpSmaller/cmpBigger are sampled only in the cycle finS is first seen high; they are stable by then under the bundled-data rule.
- cmpA/cmpB are registered and held constant from one cycle before cmpReq rises until finS falls.
- FSM states:
  - IDLE: when req=1 and finS=0, load dataIn into the array, clear swapCount, set pass=0 and the first pair index, busy=1, go to ISSUE. While finS=1 (stale datapath after reset), req is ignored.
  - ISSUE: set cmpReq=1 and wait for finS=1, then go to CAPTURE.
  - CAPTURE: write element[i]=cmpSmaller and element[i+1]=cmpBigger. If cmpSmaller != old element[i], increment swapCount. Go to RELEASE.
  - RELEASE: set cmpReq=0 and wait for finS=0, then go to ADVANCE.
  - ADVANCE: step i by 2 within the pass.
    - Pass p compares pairs (i,i+1) with i ≡ p mod 2 and i+1 < Depth.
    - A pass with no pairs (odd pass at Depth=2) is skipped in the same cycle.
    - After pass Depth-1, go to DONE. Otherwise return to ISSUE.
  - DONE: busy=0, fin=1, and wait for req=0. Then fin=0 and go to IDLE.
- Comparison count per sort: ceil(Depth/2)*floor(Depth/2) + floor(Depth/2)*floor((Depth-1)/2) over Depth passes. No early termination.
- Per-compare latency in clk cycles: 1 (issue) + datapath delay + SyncStages + 1 (capture) + SyncStages + 1 (advance).
- Equal operands: the written-back values are equal, so swapCount is unchanged.
- req falling while busy is ignored. The protocol forbids it; the sort still completes and fin rises.
- req held high after DONE→IDLE does not start a new sort; req must be seen low first.
- rst mid-operation:
  - All state clears and cmpReq drops immediately.
  - The external datapath may still hold fin=1, so IDLE blocks new work until finS=0.
- dataOut always reflects the element array. Mid-sort contents are not valid.
- swapCount saturates at its maximum value and never wraps.

Decomposition:
- Package swap_sort_pkg:
  - state enum {IDLE, ISSUE, CAPTURE, RELEASE, ADVANCE, DONE}
  - function computing swapCount width from Depth
  - function computing first pair index from pass parity
- One sub-module, fin_synchronizer: SyncStages-deep flop chain with async active-high reset to 0, instantiated on cmpFin.
- Pair indexing and the element array stay in the top module.

Test Plan:
- Depth=4, Width=8, dataIn elements [4,3,2,1], bench compareSwap model with random 1–7 cycle delay -> dataOut [1,2,3,4], swapCount=6, exactly 6 cmpReq rising edges, fin=1.
- Depth=4, input [1,2,3,4] -> dataOut unchanged, swapCount=0, still 6 compares.
- Depth=2, input [9,5] -> dataOut [5,9], swapCount=1, exactly 1 compare (odd pass skipped).
- Depth=4, input [7,7,7,7] -> dataOut unchanged, swapCount=0. Width=8 input [255,0,128,1] -> [0,1,128,255].
- rst asserted in ISSUE while bench compareSwap holds fin=1, then req=1 -> cmpReq=0 immediately. No load until the model drops fin and finS=0; then a normal sort completes.
- Four-phase checks:
  - fin stays 1 until req=0, then falls within 1 cycle.
  - req held high across DONE does not restart.
  - cmpA/cmpB stable for the whole time cmpReq=1 (assertion).
